sc_collision_lives_ctrl: RTL and testbench
==========================================

# sc_collision_lives_ctrl

Game-control stage directly downstream of the collision comparator: it samples the comparator's 1-bit collision flag at frame-update strobes and confirms a hit only after consecutive positive samples. On a confirmed hit it decrements the lives counter, freezes play for a hold interval and pulses a frog-respawn request. It declares game over when the last life is lost, and feeds the frog position register, the background scroll logic and the score/lives display.

## Interface
Parameters:
- LIVESWIDTH, 3: width of the lives counter.
- LIVES_INIT, 3: lives loaded at reset and at every game start; must be 1..2^LIVESWIDTH-1.
- CONFIRM_SAMPLES, 2: consecutive positive samples required to confirm a hit; must be at least 1.
- TIMERWIDTH, 26: width of the hold/grace timer.
- HOLD_CYCLES, 25_000_000: freeze length after a hit, in clocks (0.5 s at 50 MHz); must be at least 1.
- GRACE_CYCLES, 50_000_000: invulnerability length after a hold, in clocks; used only with the macro; must be at least 1.

Ports:
- SC_COLLISIONCTRL_CLOCK_50  in  1  system clock.
- SC_COLLISIONCTRL_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_COLLISIONCTRL_collision_In  in  1  collision flag from the comparator, active-high, combinational.
- SC_COLLISIONCTRL_sample_In  in  1  one-cycle strobe: frog and background matrices are stable.
- SC_COLLISIONCTRL_start_In  in  1  one-cycle start pulse, already debounced.
- SC_COLLISIONCTRL_lives_OutBus  out  LIVESWIDTH  lives remaining.
- SC_COLLISIONCTRL_frogReset_Out  out  1  one-cycle respawn pulse.
- SC_COLLISIONCTRL_freeze_Out  out  1  stops scrolling and frog movement.
- SC_COLLISIONCTRL_invuln_Out  out  1  high during GRACE.
- SC_COLLISIONCTRL_gameOver_Out  out  1  high in GAMEOVER.
- SC_COLLISIONCTRL_state_OutBus  out  3  state encoding, for debug.

## Operation
- States and encodings: IDLE=0, PLAY=1, HIT=2, GRACE=3, GAMEOVER=4. Encodings 5..7 are illegal and recover to IDLE.
- Reset values:
  - State IDLE; lives = LIVES_INIT.
  - frogReset 0, freeze 1, invuln 0, gameOver 0, state_OutBus 0.
  - Confirm counter 0; timer 0.
- IDLE:
  - start_In moves to PLAY, reloads lives = LIVES_INIT and pulses frogReset.
- PLAY, confirm counter:
  - Counts only on cycles with sample_In=1.
  - collision_In=1 increments the counter; collision_In=0 clears it.
  - collision_In is ignored while sample_In=0.
  - The counter saturates at CONFIRM_SAMPLES.
- PLAY, confirmed hit (the sample that makes the count reach CONFIRM_SAMPLES):
  - If lives > 1: lives decrements by 1, state moves to HIT, the timer loads HOLD_CYCLES-1, frogReset pulses.
  - If lives == 1: lives becomes 0, state moves to GAMEOVER, no frogReset.
- HIT:
  - Timer decrements every clock; samples are ignored.
  - At timer 0: next state is GRACE (macro defined) or PLAY (macro undefined).
- GRACE:
  - Timer loads GRACE_CYCLES-1 on entry and decrements every clock; collisions are ignored.
  - At timer 0: next state is PLAY.
- GAMEOVER:
  - start_In moves to PLAY, reloads lives and pulses frogReset.
- The confirm counter clears on every entry to PLAY.
- start_In is ignored in PLAY, HIT and GRACE, including in the same cycle as a confirmed hit.
- Lives never underflow and never change outside the transitions above.

## Timing
- All outputs are registered (Moore).
- Confirming sample at clock edge N: lives, state and frogReset change after edge N+1; frogReset stays high for exactly one cycle.
- freeze_Out = 1 in IDLE, HIT and GAMEOVER; 0 in PLAY and GRACE.
- Hold duration: exactly HOLD_CYCLES clocks in HIT.
- Grace duration: exactly GRACE_CYCLES clocks in GRACE.
- Reset asserted mid-game: all outputs return to their reset values immediately (asynchronous); the in-progress hit or timer is discarded.
- sample_In and start_In in the same cycle in IDLE or GAMEOVER: start wins; the sample is ignored.

## Configuration
- Macro: SC_COLLISIONCTRL_GRACE_EN.
- Defined: the GRACE state exists; invuln_Out is high during it; the GRACE_CYCLES window follows every HIT.
- Undefined:
  - HIT goes directly to PLAY; GRACE is unreachable (encoding 3 recovers to IDLE).
  - invuln_Out is tied to 0; the GRACE_CYCLES parameter is unused.

## Structure
- Shared package frogger_pkg holds:
  - State width and the localparam state encodings.
  - Default LIVES_INIT and HOLD_CYCLES constants.
- Sub-module sc_countdown_timer:
  - Loadable down-counter of width TIMERWIDTH, with load and enable inputs and a registered zero flag.
  - One instance, shared by HIT and GRACE.

## Test plan
- Reset, then start_In -> PLAY, lives=3, frogReset high for 1 cycle, freeze=0.
- CONFIRM_SAMPLES=2; two consecutive samples with collision=1 -> next cycle lives=2, state HIT, frogReset pulse, freeze=1; HOLD_CYCLES=8 gives exactly 8 cycles in HIT.
- Samples with collision 1,0,1 -> no hit, lives unchanged; collision=1 without sample_In for 100 cycles -> no hit.
- Three confirmed hits from lives=3 -> lives=0, GAMEOVER, gameOver=1, no frogReset on the last hit; start_In -> PLAY, lives=3.
- With the macro, GRACE_CYCLES=5 -> invuln=1 for 5 cycles and collisions ignored; without the macro, HIT goes straight to PLAY and invuln stays 0.
- Reset asserted during HIT -> IDLE, lives=3, freeze=1 on the same edge with no clock.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared definitions for the frogger game-control blocks.
//   - State width and state encodings of the collision/lives controller.
//   - Default lives and hold-interval constants.
//   - freeze_of(): whether play is frozen in a given state.
package frogger_pkg;

  localparam int unsigned StateW = 3;

  localparam logic [StateW-1:0] StIdle     = 3'd0;
  localparam logic [StateW-1:0] StPlay     = 3'd1;
  localparam logic [StateW-1:0] StHit      = 3'd2;
  localparam logic [StateW-1:0] StGrace    = 3'd3;
  localparam logic [StateW-1:0] StGameOver = 3'd4;

  localparam int unsigned LivesInitDef  = 3;
  localparam int unsigned HoldCyclesDef = 25_000_000;

  // Scrolling and frog movement stop in IDLE, HIT and GAMEOVER.
  function automatic logic freeze_of(input logic [StateW-1:0] st);
    return (st == StIdle) || (st == StHit) || (st == StGameOver);
  endfunction

endpackage

// File: rtl/sc_collision_lives_ctrl_if.sv
// Bus between the collision comparator / game front end and the lives controller.
//   master: drives collision flag, sample strobe and start pulse; reads status.
//   slave : the controller; reads the strobes, drives lives/respawn/freeze/
//           invuln/game-over/state.
interface sc_collision_lives_ctrl_if #(
  parameter int unsigned LIVESWIDTH = 3
);
  logic                  SC_COLLISIONCTRL_collision_In;
  logic                  SC_COLLISIONCTRL_sample_In;
  logic                  SC_COLLISIONCTRL_start_In;
  logic [LIVESWIDTH-1:0] SC_COLLISIONCTRL_lives_OutBus;
  logic                  SC_COLLISIONCTRL_frogReset_Out;
  logic                  SC_COLLISIONCTRL_freeze_Out;
  logic                  SC_COLLISIONCTRL_invuln_Out;
  logic                  SC_COLLISIONCTRL_gameOver_Out;
  logic [2:0]            SC_COLLISIONCTRL_state_OutBus;

  modport master (
    output SC_COLLISIONCTRL_collision_In,
    output SC_COLLISIONCTRL_sample_In,
    output SC_COLLISIONCTRL_start_In,
    input  SC_COLLISIONCTRL_lives_OutBus,
    input  SC_COLLISIONCTRL_frogReset_Out,
    input  SC_COLLISIONCTRL_freeze_Out,
    input  SC_COLLISIONCTRL_invuln_Out,
    input  SC_COLLISIONCTRL_gameOver_Out,
    input  SC_COLLISIONCTRL_state_OutBus
  );

  modport slave (
    input  SC_COLLISIONCTRL_collision_In,
    input  SC_COLLISIONCTRL_sample_In,
    input  SC_COLLISIONCTRL_start_In,
    output SC_COLLISIONCTRL_lives_OutBus,
    output SC_COLLISIONCTRL_frogReset_Out,
    output SC_COLLISIONCTRL_freeze_Out,
    output SC_COLLISIONCTRL_invuln_Out,
    output SC_COLLISIONCTRL_gameOver_Out,
    output SC_COLLISIONCTRL_state_OutBus
  );
endinterface

// File: rtl/sc_countdown_timer.sv
// Loadable down-counter with a registered zero flag.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_load_val (has priority over i_en)
//   i_en           : decrement by one, holding at zero
//   o_zero         : high when the count is zero
module sc_countdown_timer #(
  parameter int unsigned TIMERWIDTH = 26
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [TIMERWIDTH-1:0] i_load_val,
  input  logic                  i_en,
  output logic                  o_zero
);

  logic [TIMERWIDTH-1:0] r_cnt;
  logic                  r_zero;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_zero <= 1'b1;
    end else if (i_load) begin
      r_cnt  <= i_load_val;
      r_zero <= (i_load_val == '0);
    end else if (i_en && !r_zero) begin
      r_cnt  <= r_cnt - TIMERWIDTH'(1);
      r_zero <= (r_cnt == TIMERWIDTH'(1));
    end
  end

  assign o_zero = r_zero;

endmodule

// File: rtl/sc_collision_lives_ctrl.sv
// Collision confirmation and lives control for the frogger game.
// Samples the comparator's collision flag on frame strobes, confirms a hit after
// CONFIRM_SAMPLES consecutive positive samples, then decrements lives, freezes
// play for HOLD_CYCLES clocks and pulses a respawn, or declares game over.
//   SC_COLLISIONCTRL_CLOCK_50     : system clock
//   SC_COLLISIONCTRL_RESET_InLow  : asynchronous active-low reset
//   bus (slave)                   : strobes in; lives/frogReset/freeze/invuln/
//                                   gameOver/state out, all registered
// Optional feature macro SC_COLLISIONCTRL_GRACE_EN: adds a GRACE_CYCLES
// invulnerability window (GRACE state) after every hold.
module sc_collision_lives_ctrl
  import frogger_pkg::*;
#(
  parameter int unsigned LIVESWIDTH      = 3,
  parameter int unsigned LIVES_INIT      = LivesInitDef,
  parameter int unsigned CONFIRM_SAMPLES = 2,
  parameter int unsigned TIMERWIDTH      = 26,
  parameter int unsigned HOLD_CYCLES     = HoldCyclesDef,
  parameter int unsigned GRACE_CYCLES    = 50_000_000
) (
  input  logic SC_COLLISIONCTRL_CLOCK_50,
  input  logic SC_COLLISIONCTRL_RESET_InLow,
  sc_collision_lives_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(CONFIRM_SAMPLES + 1);
  localparam logic [CntW-1:0]       ConfN   = CntW'(CONFIRM_SAMPLES);
  localparam logic [LIVESWIDTH-1:0] LivesLd = LIVESWIDTH'(LIVES_INIT);
  localparam logic [TIMERWIDTH-1:0] HoldLd  = TIMERWIDTH'(HOLD_CYCLES - 1);
`ifdef SC_COLLISIONCTRL_GRACE_EN
  localparam logic [TIMERWIDTH-1:0] GraceLd = TIMERWIDTH'(GRACE_CYCLES - 1);
`endif

  if (LIVES_INIT < 1 || LIVES_INIT >= (2 ** LIVESWIDTH) || CONFIRM_SAMPLES < 1 ||
      HOLD_CYCLES < 1 || GRACE_CYCLES < 1) begin : g_param_err
    $error("sc_collision_lives_ctrl: illegal parameter value");
  end

  logic                  w_clk, w_rst_n;
  logic                  w_col, w_smp, w_start;
  logic [StateW-1:0]     r_state, w_state_nxt;
  logic [LIVESWIDTH-1:0] r_lives, w_lives_nxt;
  logic [CntW-1:0]       r_cnt, w_cnt_nxt;
  logic                  r_frog, w_frog_nxt;
  logic                  r_freeze, r_invuln, r_gameover;
  logic                  w_tmr_load, w_tmr_en, w_tmr_zero;
  logic [TIMERWIDTH-1:0] w_tmr_val;

  assign w_clk   = SC_COLLISIONCTRL_CLOCK_50;
  assign w_rst_n = SC_COLLISIONCTRL_RESET_InLow;
  assign w_col   = bus.SC_COLLISIONCTRL_collision_In;
  assign w_smp   = bus.SC_COLLISIONCTRL_sample_In;
  assign w_start = bus.SC_COLLISIONCTRL_start_In;

  sc_countdown_timer #(
    .TIMERWIDTH (TIMERWIDTH)
  ) u_timer (
    .i_clk      (w_clk),
    .i_rst_n    (w_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_zero     (w_tmr_zero)
  );

  // The sample that brings the counter to ConfN is acted on one clock later,
  // which is where the extra cycle of hit latency comes from.
  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_cnt_nxt   = r_cnt;
    w_frog_nxt  = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = HoldLd;
    w_tmr_en    = 1'b0;
    case (r_state)
      StIdle, StGameOver: begin
        if (w_start) begin
          w_state_nxt = StPlay;
          w_lives_nxt = LivesLd;
          w_frog_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      StPlay: begin
        if (r_cnt == ConfN) begin
          w_cnt_nxt = '0;
          if (r_lives > LIVESWIDTH'(1)) begin
            w_lives_nxt = r_lives - LIVESWIDTH'(1);
            w_state_nxt = StHit;
            w_tmr_load  = 1'b1;
            w_frog_nxt  = 1'b1;
          end else begin
            w_lives_nxt = '0;
            w_state_nxt = StGameOver;
          end
        end else if (w_smp) begin
          w_cnt_nxt = w_col ? r_cnt + CntW'(1) : '0;
        end
      end
      StHit: begin
        if (w_tmr_zero) begin
`ifdef SC_COLLISIONCTRL_GRACE_EN
          w_state_nxt = StGrace;
          w_tmr_load  = 1'b1;
          w_tmr_val   = GraceLd;
`else
          w_state_nxt = StPlay;
          w_cnt_nxt   = '0;
`endif
        end else begin
          w_tmr_en = 1'b1;
        end
      end
`ifdef SC_COLLISIONCTRL_GRACE_EN
      StGrace: begin
        if (w_tmr_zero) begin
          w_state_nxt = StPlay;
          w_cnt_nxt   = '0;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
`endif
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= StIdle;
      r_lives    <= LivesLd;
      r_cnt      <= '0;
      r_frog     <= 1'b0;
      r_freeze   <= 1'b1;
      r_invuln   <= 1'b0;
      r_gameover <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lives    <= w_lives_nxt;
      r_cnt      <= w_cnt_nxt;
      r_frog     <= w_frog_nxt;
      r_freeze   <= freeze_of(w_state_nxt);
`ifdef SC_COLLISIONCTRL_GRACE_EN
      r_invuln   <= (w_state_nxt == StGrace);
`else
      r_invuln   <= 1'b0;
`endif
      r_gameover <= (w_state_nxt == StGameOver);
    end
  end

  assign bus.SC_COLLISIONCTRL_lives_OutBus  = r_lives;
  assign bus.SC_COLLISIONCTRL_frogReset_Out = r_frog;
  assign bus.SC_COLLISIONCTRL_freeze_Out    = r_freeze;
  assign bus.SC_COLLISIONCTRL_invuln_Out    = r_invuln;
  assign bus.SC_COLLISIONCTRL_gameOver_Out  = r_gameover;
  assign bus.SC_COLLISIONCTRL_state_OutBus  = r_state;

endmodule

// File: tb/tb_sc_collision_lives_ctrl.sv
// Scoreboard bench for sc_collision_lives_ctrl: a behavioural game model
// pushes the expected output vector each cycle; it is popped and compared on
// the following falling edge. Vector = {state, lives, frogReset, freeze,
// invuln, gameOver}.
module tb_sc_collision_lives_ctrl;

  localparam int unsigned LW    = 3;
  localparam int unsigned LI    = 3;
  localparam int unsigned CS    = 2;
  localparam int unsigned HOLD  = 8;
  localparam int unsigned GRACE = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sc_collision_lives_ctrl_if #(.LIVESWIDTH(LW)) bus ();

  sc_collision_lives_ctrl #(
    .LIVESWIDTH      (LW),
    .LIVES_INIT      (LI),
    .CONFIRM_SAMPLES (CS),
    .TIMERWIDTH      (26),
    .HOLD_CYCLES     (HOLD),
    .GRACE_CYCLES    (GRACE)
  ) dut (
    .SC_COLLISIONCTRL_CLOCK_50    (clk),
    .SC_COLLISIONCTRL_RESET_InLow (rst_n),
    .bus                          (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q[$];

  // Reference model state
  int m_state, m_lives, m_cnt, m_tmr;
  bit m_frog;

  task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b want=%b (state,lives,frog,freeze,invuln,gameover) t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] model_vec();
    logic fz;
    fz = (m_state == 0) || (m_state == 2) || (m_state == 4);
    return {3'(m_state), 3'(m_lives), m_frog, fz, (m_state == 3), (m_state == 4)};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {bus.SC_COLLISIONCTRL_state_OutBus, bus.SC_COLLISIONCTRL_lives_OutBus,
            bus.SC_COLLISIONCTRL_frogReset_Out, bus.SC_COLLISIONCTRL_freeze_Out,
            bus.SC_COLLISIONCTRL_invuln_Out, bus.SC_COLLISIONCTRL_gameOver_Out};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_lives = LI;
    m_cnt   = 0;
    m_tmr   = 0;
    m_frog  = 0;
  endtask

  // One clock of the game as described: m_tmr counts remaining cycles in HIT/GRACE.
  task automatic model_step(input bit c, input bit s, input bit t);
    m_frog = 0;
    case (m_state)
      0, 4: if (t) begin
        m_state = 1; m_lives = LI; m_frog = 1; m_cnt = 0;
      end
      1: begin
        if (m_cnt == CS) begin
          m_cnt = 0;
          if (m_lives > 1) begin
            m_lives--; m_state = 2; m_tmr = HOLD; m_frog = 1;
          end else begin
            m_lives = 0; m_state = 4;
          end
        end else if (s) begin
          m_cnt = c ? m_cnt + 1 : 0;
        end
      end
      2: begin
        m_tmr--;
        if (m_tmr == 0) begin
`ifdef SC_COLLISIONCTRL_GRACE_EN
          m_state = 3; m_tmr = GRACE;
`else
          m_state = 1; m_cnt = 0;
`endif
        end
      end
      3: begin
        m_tmr--;
        if (m_tmr == 0) begin
          m_state = 1; m_cnt = 0;
        end
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic cyc(input bit c, input bit s, input bit t, input string tag);
    bus.SC_COLLISIONCTRL_collision_In = c;
    bus.SC_COLLISIONCTRL_sample_In    = s;
    bus.SC_COLLISIONCTRL_start_In     = t;
    model_step(c, s, t);
    exp_q.push_back(model_vec());
    @(posedge clk);
    @(negedge clk);
    check_eq(tag, dut_vec(), exp_q.pop_front());
  endtask

  task automatic check_now(input string tag);
    exp_q.push_back(model_vec());
    check_eq(tag, dut_vec(), exp_q.pop_front());
  endtask

  initial begin
    bus.SC_COLLISIONCTRL_collision_In = 1'b0;
    bus.SC_COLLISIONCTRL_sample_In    = 1'b0;
    bus.SC_COLLISIONCTRL_start_In     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_now("reset");
    rst_n = 1'b1;

    cyc(0, 1, 0, "idle_sample_ignored");
    cyc(0, 0, 1, "start");
    cyc(0, 0, 0, "play");

    // First hit, samples during the hold are ignored
    cyc(1, 1, 0, "hit1_s1");
    cyc(1, 1, 0, "hit1_s2");
    cyc(0, 0, 0, "hit1_enter");
    repeat (HOLD - 1) cyc(1, 1, 0, "hold1");
`ifdef SC_COLLISIONCTRL_GRACE_EN
    repeat (GRACE + 1) cyc(1, 1, 0, "grace1");
`endif
    cyc(0, 0, 0, "back_to_play");

    // Interrupted run and collisions without a strobe
    cyc(1, 1, 0, "p101_a");
    cyc(0, 1, 0, "p101_b");
    cyc(1, 1, 0, "p101_c");
    cyc(0, 0, 0, "p101_d");
    repeat (100) cyc(1, 0, 0, "no_strobe");
    cyc(0, 1, 0, "clear");

    // Second hit with a start pulse on the confirming cycle
    cyc(1, 1, 0, "hit2_s1");
    cyc(1, 1, 0, "hit2_s2");
    cyc(0, 0, 1, "hit2_start_ignored");
    repeat (HOLD + GRACE + 2) cyc(0, 0, 0, "hold2");

    // Last life: game over without respawn, then restart with start+sample
    cyc(1, 1, 0, "hit3_s1");
    cyc(1, 1, 0, "hit3_s2");
    cyc(0, 0, 0, "gameover");
    cyc(1, 1, 0, "gameover_hold");
    cyc(1, 1, 1, "restart_start_wins");
    cyc(1, 1, 0, "restart_s1");
    cyc(0, 0, 0, "restart_no_hit");

    // Reset in the middle of a hold
    cyc(0, 1, 0, "clear2");
    cyc(1, 1, 0, "hit4_s1");
    cyc(1, 1, 0, "hit4_s2");
    cyc(0, 0, 0, "hit4_enter");
    repeat (3) cyc(0, 0, 0, "hold4");
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_now("async_reset");
    #1 rst_n = 1'b1;

    // Random traffic
    cyc(0, 0, 1, "rand_start");
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 40) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
